// File: rtl/alu_seq_ctrl_if.sv
// Command, register-file and ALU signal bundle for alu_seq_ctrl.
// The controller uses the master modport; the command source plus datapath use slave.
interface alu_seq_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_out;
  logic        done;
  logic        err;
  logic        flag_zero;
  logic        flag_neg;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, rf_rd, alu_out,
    output cmd_ready, rf_ra, rf_we, rf_wa, rf_wd, alu_a, alu_b, alu_op,
           done, err, flag_zero, flag_neg
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, rf_rd, alu_out,
    input  cmd_ready, rf_ra, rf_we, rf_wa, rf_wd, alu_a, alu_b, alu_op,
           done, err, flag_zero, flag_neg
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Read-rs / read-rt / execute / write-rd sequencer; result flags built only with ALU_SEQ_FLAGS_EN.
// WB (rf_we, done) lands 4 cycles after acceptance; cmd_ready is high only in IDLE, so one command per 5 cycles.
module alu_seq_ctrl #(
  parameter int N_OPS = 7
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_LIMIT = 5'(N_OPS);

  logic [2:0]  state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] res_q, res_d;
  logic        op_illegal;

  assign op_illegal = (op_q >= OP_LIMIT);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = S_RD_A;
          op_d    = bus.cmd_op;
          rd_d    = bus.cmd_rd;
          rs_d    = bus.cmd_rs;
          rt_d    = bus.cmd_rt;
        end
      end
      S_RD_A: begin
        opa_d   = bus.rf_rd;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        opb_d   = bus.rf_rd;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Illegal ops never reach the register file, so force a clean zero result.
        res_d   = op_illegal ? 32'd0 : bus.alu_out;
        state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rf_ra     = (state_q == S_RD_A) ? rs_q :
                         (state_q == S_RD_B) ? rt_q : 5'd0;
  assign bus.alu_a     = (state_q == S_EXEC) ? opa_q : 32'd0;
  assign bus.alu_b     = (state_q == S_EXEC) ? opb_q : 32'd0;
  assign bus.alu_op    = (state_q == S_EXEC && !op_illegal) ? op_q : OP_NOP;
  assign bus.rf_we     = (state_q == S_WB) && !op_illegal && (op_q != OP_NOP);
  assign bus.rf_wa     = (state_q == S_WB) ? rd_q : 5'd0;
  assign bus.rf_wd     = (state_q == S_WB) ? res_q : 32'd0;
  assign bus.done      = (state_q == S_WB);
  assign bus.err       = (state_q == S_WB) && op_illegal;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  // Flags follow the value being latched into the result register, so they hold until the next EXEC.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (state_q == S_EXEC) begin
      zero_d = (res_d == 32'd0);
      neg_d  = res_d[31];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign bus.flag_zero = zero_q;
  assign bus.flag_neg  = neg_q;
`else
  assign bus.flag_zero = 1'b0;
  assign bus.flag_neg  = 1'b0;
`endif
endmodule
